rtc_bcd_timer: RTL and testbench
================================

# rtc_bcd_timer

Parametrised BCD time-keeping core that generalises the fixed six-digit real-time clock into a reusable timer/stopwatch: run/pause, up or down counting, per-field load with validation, lap freeze and configurable hour modulus. It sits between the board clock and the seven-segment decoders in top-level designs. It drives four two-digit BCD fields (hundredths, seconds, minutes, hours) that the decoders consume directly.

## Interface
- CLK_DIV, default 500000: clk cycles per hundredth-second tick (50 MHz -> 100 Hz); legal range >= 2.
- HOUR_MOD, default 24: hour field modulus; legal range 1..100.
- clk  in  1  system clock; all state changes on its rising edge.
- clr  in  1  reset, synchronous, active-high; highest priority.
- run  in  1  level; 1 = prescaler advances, 0 = paused (prescaler and fields hold).
- dir  in  1  0 = count up, 1 = count down.
- lap  in  1  single-cycle pulse; toggles display freeze.
- load  in  1  single-cycle pulse; writes load_val into the field selected by load_sel.
- load_sel  in  2  0 = hundredths, 1 = seconds, 2 = minutes, 3 = hours.
- load_val  in  8  two BCD digits, tens in [7:4], units in [3:0].
- cs_bcd, sec_bcd, min_bcd, hr_bcd  out  8 each  displayed BCD fields, tens in [7:4].
- tick  out  1  one-cycle pulse on every prescaler terminal count.
- frozen  out  1  1 while the display shows a lap snapshot.
- done  out  1  one-cycle pulse when a down-count reaches 00:00:00.00.
- load_err  out  1  one-cycle pulse when a load is rejected.

## Operation
- Prescaler counts 0..CLK_DIV-1 only while run=1. tick=1 in the cycle the prescaler equals CLK_DIV-1 with run=1, and the prescaler wraps to 0 on that edge.
- Live fields use BCD arithmetic, never binary-to-BCD conversion. Limits: cs 99, sec 59, min 59, hr HOUR_MOD-1.
- Up (dir=0), on tick: cs+1. A field at its limit wraps to 00 and carries into the next field. hr at HOUR_MOD-1 with carry wraps to 00, giving a full rollover to all zero with no flag.
- Down (dir=1), on tick: cs-1. A field at 00 wraps to its limit and borrows from the next field.
  - All fields zero: the count saturates and holds, the tick is consumed, done stays 0.
  - A tick that makes the value all-zero from nonzero pulses done in the same cycle the zero value becomes visible.
- Load: accepted only if both digits are <= 9 and the value is <= the field limit. On accept, the selected live field takes load_val and the prescaler clears to 0. On reject, nothing changes and load_err pulses.
- Lap: when frozen=0, lap copies the live fields into the snapshot registers and sets frozen=1. When frozen=1, lap clears frozen. The live count continues throughout.
- Outputs show the snapshot when frozen=1 and the live fields otherwise.
- Priority in one cycle: clr > load > tick.
  - load with tick: the load is applied and the tick increment is dropped. tick still pulses and the prescaler clears.
  - lap with load: the lap snapshot captures the pre-load live value.
- dir changes take effect at the next tick. No other state changes on a dir change.

## Timing
- Reset (clr=1 at an edge): prescaler 0, all live and snapshot fields 00, frozen 0, tick 0, done 0, load_err 0. Outputs read 00:00:00.00 the cycle after.
- All outputs are registered. A field update from a tick appears on the edge where tick=1 is sampled, one cycle after the prescaler reaches CLK_DIV-2.
- After reset with run=1 held, the first tick occurs CLK_DIV cycles after clr deasserts.
- Load and lap take effect on the clocking edge. The new value is visible the next cycle.
- clr asserted mid-count or while frozen discards all state, including the snapshot.

## Test plan
- CLK_DIV=4, HOUR_MOD=24, clr then run=1 for 400 cycles -> tick every 4th cycle; cs_bcd=8'h00 and sec_bcd=8'h01 after the 100th tick.
- Load hr=23, min=59, sec=59, cs=99, dir=0, one tick -> all fields 8'h00, done=0.
- Load sec=8'h01, dir=1, 100 ticks -> done pulses once with all fields 00. A further 10 ticks keep all fields 00 with done=0.
- Load cs=8'h9A, then sec=8'h60, then with HOUR_MOD=12 hr=8'h12 -> load_err pulses for each, fields unchanged. Load min=8'h45 -> min_bcd=8'h45, prescaler cleared.
- Run to cs=8'h37, pulse lap -> frozen=1 with outputs stuck at 37 while ticks continue. After 5 ticks, pulse lap -> outputs show live cs=8'h42.
- Pulse load in the same cycle as tick -> loaded value is held with no increment. Assert clr while frozen and running -> all outputs 0 next cycle, frozen=0.

Source files
------------

// File: rtl/rtc_bcd_timer.sv
// BCD timer/stopwatch core. Four two-digit BCD fields (hundredths, seconds, minutes, hours)
// with run/pause, up/down counting, validated per-field load, lap freeze and a parametrised hour modulus.
module rtc_bcd_timer #(
  parameter int CLK_DIV  = 500000,
  parameter int HOUR_MOD = 24
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       run,
  input  logic       dir,
  input  logic       lap,
  input  logic       load,
  input  logic [1:0] load_sel,
  input  logic [7:0] load_val,
  output logic [7:0] cs_bcd,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hr_bcd,
  output logic       tick,
  output logic       frozen,
  output logic       done,
  output logic       load_err
);

  localparam int             PW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [7:0]     HR_LIM   = {4'((HOUR_MOD - 1) / 10), 4'((HOUR_MOD - 1) % 10)};
  localparam logic [7:0]     CS_LIM   = 8'h99;
  localparam logic [7:0]     MS_LIM   = 8'h59;

  // Returns {carry, next}: increment with wrap to 00 at the field limit.
  function automatic logic [8:0] bcd_up(input logic [7:0] v, input logic [7:0] lim);
    if (v == lim)              return 9'h100;
    else if (v[3:0] == 4'd9)   return {1'b0, v[7:4] + 4'd1, 4'd0};
    else                       return {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction

  // Returns {borrow, next}: decrement with wrap from 00 to the field limit.
  function automatic logic [8:0] bcd_dn(input logic [7:0] v, input logic [7:0] lim);
    if (v == 8'h00)            return {1'b1, lim};
    else if (v[3:0] == 4'd0)   return {1'b0, v[7:4] - 4'd1, 4'd9};
    else                       return {1'b0, v[7:4], v[3:0] - 4'd1};
  endfunction

  logic [PW-1:0] presc, presc_n;
  logic [7:0]    cs, sec, mn, hr;
  logic [7:0]    cs_n, sec_n, mn_n, hr_n;
  logic [7:0]    s_cs, s_sec, s_mn, s_hr;
  logic [7:0]    s_cs_n, s_sec_n, s_mn_n, s_hr_n;
  logic          frozen_n, tick_n, done_n, err_n;
  logic [7:0]    load_lim;
  logic          load_ok, accept, all_zero;
  logic [8:0]    u_cs, u_sec, u_mn, u_hr;
  logic [8:0]    d_cs, d_sec, d_mn, d_hr;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    presc_n  = presc;
    cs_n     = cs;
    sec_n    = sec;
    mn_n     = mn;
    hr_n     = hr;
    s_cs_n   = s_cs;
    s_sec_n  = s_sec;
    s_mn_n   = s_mn;
    s_hr_n   = s_hr;
    frozen_n = frozen;
    done_n   = 1'b0;

    case (load_sel)
      2'd0:    load_lim = CS_LIM;
      2'd1:    load_lim = MS_LIM;
      2'd2:    load_lim = MS_LIM;
      default: load_lim = HR_LIM;
    endcase
    load_ok  = (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9) && (load_val <= load_lim);
    accept   = load && load_ok;
    err_n    = load && !load_ok;
    all_zero = ({cs, sec, mn, hr} == 32'h0);

    u_cs  = bcd_up(cs,  CS_LIM);
    u_sec = bcd_up(sec, MS_LIM);
    u_mn  = bcd_up(mn,  MS_LIM);
    u_hr  = bcd_up(hr,  HR_LIM);
    d_cs  = bcd_dn(cs,  CS_LIM);
    d_sec = bcd_dn(sec, MS_LIM);
    d_mn  = bcd_dn(mn,  MS_LIM);
    d_hr  = bcd_dn(hr,  HR_LIM);

    // tick is the registered terminal-count flag for the current cycle.
    if (accept || tick) presc_n = '0;
    else if (run)       presc_n = presc + 1'b1;

    if (accept) begin
      case (load_sel)
        2'd0:    cs_n  = load_val;
        2'd1:    sec_n = load_val;
        2'd2:    mn_n  = load_val;
        default: hr_n  = load_val;
      endcase
    end else if (tick && !dir) begin
      cs_n = u_cs[7:0];
      if (u_cs[8])                       sec_n = u_sec[7:0];
      if (u_cs[8] && u_sec[8])           mn_n  = u_mn[7:0];
      if (u_cs[8] && u_sec[8] && u_mn[8]) hr_n = u_hr[7:0];
    end else if (tick && dir && !all_zero) begin
      cs_n = d_cs[7:0];
      if (d_cs[8])                       sec_n = d_sec[7:0];
      if (d_cs[8] && d_sec[8])           mn_n  = d_mn[7:0];
      if (d_cs[8] && d_sec[8] && d_mn[8]) hr_n = d_hr[7:0];
      done_n = ({cs_n, sec_n, mn_n, hr_n} == 32'h0);
    end

    // The snapshot takes the pre-load live value.
    if (lap && !frozen) begin
      s_cs_n   = cs;
      s_sec_n  = sec;
      s_mn_n   = mn;
      s_hr_n   = hr;
      frozen_n = 1'b1;
    end else if (lap) begin
      frozen_n = 1'b0;
    end

    tick_n = (presc_n == PRE_LAST);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      presc    <= '0;
      cs       <= '0;
      sec      <= '0;
      mn       <= '0;
      hr       <= '0;
      s_cs     <= '0;
      s_sec    <= '0;
      s_mn     <= '0;
      s_hr     <= '0;
      frozen   <= 1'b0;
      tick     <= 1'b0;
      done     <= 1'b0;
      load_err <= 1'b0;
      cs_bcd   <= '0;
      sec_bcd  <= '0;
      min_bcd  <= '0;
      hr_bcd   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      presc    <= presc_n;
      cs       <= cs_n;
      sec      <= sec_n;
      mn       <= mn_n;
      hr       <= hr_n;
      s_cs     <= s_cs_n;
      s_sec    <= s_sec_n;
      s_mn     <= s_mn_n;
      s_hr     <= s_hr_n;
      frozen   <= frozen_n;
      tick     <= tick_n;
      done     <= done_n;
      load_err <= err_n;
      cs_bcd   <= frozen_n ? s_cs_n  : cs_n;
      sec_bcd  <= frozen_n ? s_sec_n : sec_n;
      min_bcd  <= frozen_n ? s_mn_n  : mn_n;
      hr_bcd   <= frozen_n ? s_hr_n  : hr_n;
    end
  end

endmodule

// File: tb/tb_rtc_bcd_timer.sv
// Directed bench for rtc_bcd_timer (CLK_DIV=4); a second instance with HOUR_MOD=12
// shares the inputs and is used for the hour-limit load check.
module tb_rtc_bcd_timer;
  logic       clk = 1'b0;
  logic       clr, run, dir, lap, load;
  logic [1:0] load_sel;
  logic [7:0] load_val;
  logic [7:0] cs_bcd, sec_bcd, min_bcd, hr_bcd;
  logic       tick, frozen, done, load_err;
  logic [7:0] cs12, sec12, min12, hr12;
  logic       tick12, frozen12, done12, err12;
  int total = 0;
  int bad   = 0;

  rtc_bcd_timer #(.CLK_DIV(4), .HOUR_MOD(24)) dut (
    .clk(clk), .clr(clr), .run(run), .dir(dir), .lap(lap), .load(load),
    .load_sel(load_sel), .load_val(load_val),
    .cs_bcd(cs_bcd), .sec_bcd(sec_bcd), .min_bcd(min_bcd), .hr_bcd(hr_bcd),
    .tick(tick), .frozen(frozen), .done(done), .load_err(load_err));

  rtc_bcd_timer #(.CLK_DIV(4), .HOUR_MOD(12)) dut12 (
    .clk(clk), .clr(clr), .run(run), .dir(dir), .lap(lap), .load(load),
    .load_sel(load_sel), .load_val(load_val),
    .cs_bcd(cs12), .sec_bcd(sec12), .min_bcd(min12), .hr_bcd(hr12),
    .tick(tick12), .frozen(frozen12), .done(done12), .load_err(err12));

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [1:0] sel, input logic [7:0] val);
    load = 1'b1; load_sel = sel; load_val = val;
    step(1);
    load = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step(1);
    clr = 1'b0;
  endtask

  task automatic wait_tick(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tick) begin ok = 1'b1; break; end
      step(1);
    end
    total++;
    if (!ok) begin bad++; $display("FAIL %s: tick not seen within 20 cycles", name); end
  endtask

  task automatic test_reset();
    clr = 1'b1; run = 1'b0; dir = 1'b0; lap = 1'b0; load = 1'b0;
    load_sel = 2'd0; load_val = 8'h00;
    step(2);
    clr = 1'b0;
    total++;
    if ({cs_bcd, sec_bcd, min_bcd, hr_bcd} !== 32'h0) begin
      bad++; $display("FAIL reset_fields: got %h want 0", {cs_bcd, sec_bcd, min_bcd, hr_bcd});
    end
    total++;
    if ({tick, frozen, done, load_err} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags: got %b want 0000", {tick, frozen, done, load_err});
    end
  endtask

  task automatic test_count_up();
    int nt = 0, bad_pos = 0;
    clr = 1'b1; run = 1'b1;
    step(1);
    clr = 1'b0;
    for (int i = 1; i <= 400; i++) begin
      step(1);
      if (tick) begin
        nt++;
        if ((i % 4) != 3) bad_pos++;
      end
    end
    run = 1'b0;
    total++;
    if (nt !== 100) begin bad++; $display("FAIL up_tick_count: got %0d want 100", nt); end
    total++;
    if (bad_pos !== 0) begin bad++; $display("FAIL up_tick_spacing: got %0d misplaced want 0", bad_pos); end
    total++;
    if ({cs_bcd, sec_bcd, min_bcd, hr_bcd} !== 32'h00010000) begin
      bad++; $display("FAIL up_100_ticks: got %h want 00010000", {cs_bcd, sec_bcd, min_bcd, hr_bcd});
    end
  endtask

  task automatic test_rollover();
    do_load(2'd3, 8'h23);
    do_load(2'd2, 8'h59);
    do_load(2'd1, 8'h59);
    do_load(2'd0, 8'h99);
    total++;
    if ({cs_bcd, sec_bcd, min_bcd, hr_bcd} !== 32'h99595923) begin
      bad++; $display("FAIL rollover_load: got %h want 99595923", {cs_bcd, sec_bcd, min_bcd, hr_bcd});
    end
    dir = 1'b0; run = 1'b1;
    wait_tick("rollover_tick");
    step(1);
    run = 1'b0;
    total++;
    if ({cs_bcd, sec_bcd, min_bcd, hr_bcd, done} !== 33'h0) begin
      bad++; $display("FAIL rollover_zero: got %h done=%b want 0 done=0",
                      {cs_bcd, sec_bcd, min_bcd, hr_bcd}, done);
    end
  endtask

  task automatic test_down_done();
    int nd = 0, done_at = -1, nd2 = 0, nt2 = 0, nz_after = 0;
    do_clr();
    do_load(2'd1, 8'h01);
    dir = 1'b1; run = 1'b1;
    for (int i = 1; i <= 400; i++) begin
      step(1);
      if (done) begin nd++; done_at = i; end
    end
    total++;
    if (nd !== 1) begin bad++; $display("FAIL down_done_count: got %0d want 1", nd); end
    total++;
    if (done_at !== 400) begin bad++; $display("FAIL down_done_cycle: got %0d want 400", done_at); end
    total++;
    if ({cs_bcd, sec_bcd, min_bcd, hr_bcd} !== 32'h0) begin
      bad++; $display("FAIL down_zero: got %h want 0", {cs_bcd, sec_bcd, min_bcd, hr_bcd});
    end
    for (int i = 1; i <= 40; i++) begin
      step(1);
      if (done) nd2++;
      if (tick) nt2++;
      if ({cs_bcd, sec_bcd, min_bcd, hr_bcd} !== 32'h0) nz_after++;
    end
    run = 1'b0; dir = 1'b0;
    total++;
    if (nd2 !== 0) begin bad++; $display("FAIL down_saturate_done: got %0d want 0", nd2); end
    total++;
    if (nt2 !== 10) begin bad++; $display("FAIL down_saturate_ticks: got %0d want 10", nt2); end
    total++;
    if (nz_after !== 0) begin bad++; $display("FAIL down_saturate_hold: got %0d nonzero cycles want 0", nz_after); end
  endtask

  task automatic test_load_err();
    int n = 0;
    do_clr();
    do_load(2'd0, 8'h9A);
    total++;
    if ({load_err, cs_bcd} !== 9'h100) begin
      bad++; $display("FAIL err_cs_9A: got err=%b cs=%h want err=1 cs=00", load_err, cs_bcd);
    end
    do_load(2'd1, 8'h60);
    total++;
    if ({load_err, sec_bcd} !== 9'h100) begin
      bad++; $display("FAIL err_sec_60: got err=%b sec=%h want err=1 sec=00", load_err, sec_bcd);
    end
    do_load(2'd3, 8'h12);
    total++;
    if ({err12, hr12} !== 9'h100) begin
      bad++; $display("FAIL err_hr12: got err=%b hr=%h want err=1 hr=00", err12, hr12);
    end
    total++;
    if ({load_err, hr_bcd} !== 9'h012) begin
      bad++; $display("FAIL ok_hr24: got err=%b hr=%h want err=0 hr=12", load_err, hr_bcd);
    end
    step(1);
    total++;
    if ({load_err, err12} !== 2'b00) begin
      bad++; $display("FAIL err_pulse_width: got %b want 00", {load_err, err12});
    end
    run = 1'b1;
    step(2);
    run = 1'b0;
    do_load(2'd2, 8'h45);
    total++;
    if ({load_err, min_bcd} !== 9'h045) begin
      bad++; $display("FAIL load_min: got err=%b min=%h want err=0 min=45", load_err, min_bcd);
    end
    run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (tick) break;
      step(1);
      n++;
    end
    run = 1'b0;
    step(1);
    total++;
    if (n !== 3) begin bad++; $display("FAIL load_presc_clear: got %0d cycles to tick want 3", n); end
  endtask

  task automatic test_lap();
    int stuck_bad = 0;
    do_clr();
    do_load(2'd0, 8'h33);
    run = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_tick("lap_pre_tick");
      step(1);
    end
    total++;
    if (cs_bcd !== 8'h37) begin bad++; $display("FAIL lap_pre: got cs=%h want 37", cs_bcd); end
    lap = 1'b1;
    step(1);
    lap = 1'b0;
    total++;
    if ({frozen, cs_bcd} !== 9'h137) begin
      bad++; $display("FAIL lap_freeze: got frozen=%b cs=%h want 1/37", frozen, cs_bcd);
    end
    for (int k = 0; k < 5; k++) begin
      wait_tick("lap_run_tick");
      step(1);
      if ({frozen, cs_bcd} !== 9'h137) stuck_bad++;
    end
    total++;
    if (stuck_bad !== 0) begin bad++; $display("FAIL lap_hold: got %0d moved cycles want 0", stuck_bad); end
    lap = 1'b1;
    step(1);
    lap = 1'b0;
    run = 1'b0;
    total++;
    if ({frozen, cs_bcd} !== 9'h042) begin
      bad++; $display("FAIL lap_release: got frozen=%b cs=%h want 0/42", frozen, cs_bcd);
    end
  endtask

  task automatic test_load_tick();
    int n = 0;
    do_clr();
    dir = 1'b0; run = 1'b1;
    wait_tick("load_tick_wait");
    load = 1'b1; load_sel = 2'd0; load_val = 8'h50;
    step(1);
    load = 1'b0;
    total++;
    if ({load_err, cs_bcd} !== 9'h050) begin
      bad++; $display("FAIL load_with_tick: got err=%b cs=%h want 0/50", load_err, cs_bcd);
    end
    for (int i = 0; i < 10; i++) begin
      if (tick) break;
      step(1);
      n++;
    end
    total++;
    if (n !== 3) begin bad++; $display("FAIL load_tick_presc: got %0d cycles to tick want 3", n); end
  endtask

  task automatic test_clr_frozen();
    run = 1'b1;
    lap = 1'b1;
    step(1);
    lap = 1'b0;
    step(5);
    total++;
    if (frozen !== 1'b1) begin bad++; $display("FAIL clr_pre_frozen: got %b want 1", frozen); end
    do_clr();
    total++;
    if ({cs_bcd, sec_bcd, min_bcd, hr_bcd, tick, frozen, done, load_err} !== 36'h0) begin
      bad++; $display("FAIL clr_frozen: got %h flags=%b want 0",
                      {cs_bcd, sec_bcd, min_bcd, hr_bcd}, {tick, frozen, done, load_err});
    end
    wait_tick("clr_restart_tick");
    step(1);
    run = 1'b0;
    total++;
    if ({frozen, cs_bcd} !== 9'h001) begin
      bad++; $display("FAIL clr_restart: got frozen=%b cs=%h want 0/01", frozen, cs_bcd);
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_rollover();
    test_down_done();
    test_load_err();
    test_lap();
    test_load_tick();
    test_clr_frozen();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
